td4x_core: RTL and testbench
============================

TD4X_CORE -- requirements
Module: td4x_core

Interface
REQ-001 SHALL have parameter DW, default 4, data/register/immediate width (>=4).
REQ-002 SHALL have parameter AW, default 4, program address width (1..16).
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port inp  input  DW  external input port, read by IN instructions.
REQ-006 SHALL have port outp  output  DW  registered output port (C register).
REQ-007 SHALL have port out_valid  output  1  one-cycle strobe when outp is written.
REQ-008 SHALL have port imem_req  output  1  instruction fetch request.
REQ-009 SHALL have port imem_addr  output  AW  fetch address (current PC).
REQ-010 SHALL have port imem_ack  input  1  fetch acknowledge; imem_data is valid in the same cycle.
REQ-011 SHALL have port imem_data  input  4+DW  instruction: [DW+3:DW] opcode, [DW-1:0] immediate.
REQ-012 SHALL have port halted  output  1  core is in HALT state.

Function
REQ-013 SHALL use FSM states FETCH, EXEC, HALT.
REQ-014 FETCH: imem_req=1 and imem_addr=PC; on imem_ack, latch imem_data into IR and go to EXEC. Otherwise stay in FETCH with address held stable.
REQ-015 EXEC: execute IR in exactly one cycle, update registers/PC/carry, then go to FETCH. Minimum 2 cycles per instruction.
REQ-016 SHALL implement the following opcodes, with IM = immediate:
- 0000 ADD A,IM
- 0001 MOV A,B
- 0010 IN A
- 0011 MOV A,IM
- 0100 MOV B,A
- 0101 ADD B,IM
- 0110 IN B
- 0111 MOV B,IM
- 1001 OUT B
- 1011 OUT IM
- 1110 JNC IM
- 1111 JMP IM
REQ-017 ADD: DW-bit sum, truncated; carry = carry-out of the addition.
REQ-018 Every non-ADD instruction executed SHALL clear carry.
REQ-019 JNC SHALL test the carry value from before the current instruction; if carry=0 then PC=target, else PC=PC+1.
REQ-020 Jump target SHALL be IM[AW-1:0] when AW<=DW, else IM zero-extended to AW.
REQ-021 Non-jump instructions SHALL set PC=PC+1 modulo 2^AW; 2^AW-1 wraps to 0.
REQ-022 OUT SHALL update outp and pulse out_valid high for exactly the EXEC cycle's following clock (one cycle).
REQ-023 Undefined opcodes (1010, 1100, 1101, and 1000 when halt is disabled) SHALL behave as NOP: PC+1, carry cleared.
REQ-024 imem_req SHALL be 0 in EXEC and HALT. An imem_ack outside FETCH SHALL be ignored.

Reset
REQ-025 When reset=0 at a clock edge, the following SHALL be set: A=B=0, outp=0, out_valid=0, PC=0, carry=0, IR=0, state=FETCH, halted=0.
REQ-026 Reset SHALL override everything, including an in-flight fetch: a pending ack is discarded and fetch restarts at address 0.

Configuration
REQ-027 Macro TD4X_HALT_EN:
- Defined: opcode 1000 enters HALT. halted=1, imem_req=0, and all state is frozen until reset.
- Undefined: 1000 is a NOP and halted is tied to 0.

Structure
REQ-028 Package td4x_pkg SHALL hold opcode constants and the FSM state enum.
REQ-029 Sub-module td4x_alu (DW-bit adder, carry out, parameter DW) SHALL be instantiated once.

Verification (DW=4, AW=4, ack in the same cycle as req unless stated)
REQ-030 Reset: hold reset=0 for 2 cycles, then release. Expected: outp=0, out_valid=0, imem_req=1, imem_addr=0, halted=0.
REQ-031 Carry: program MOV A,F; ADD A,1; JNC 7. Expected: A=0, carry=1, JNC not taken, next fetch at address 3.
REQ-032 Stall: imem_ack delayed 3 cycles on address 2. Expected: imem_addr=2 held stable, A/B/outp unchanged until the ack.
REQ-033 Output: program MOV B,A; OUT B with A=0xA. Expected: outp=0xA, out_valid high for exactly 1 cycle.
REQ-034 Wrap: JMP F, then ADD A,0 at address F. Expected: the next fetch address is 0 and carry=0.
REQ-035 Halt (TD4X_HALT_EN defined): opcode 1000 at address 1. Expected: halted=1, imem_req=0 for 10 cycles; after a reset pulse, fetch resumes at address 0.

Source files
------------

// File: rtl/td4x_pkg.sv
// td4x_pkg: opcode constants, FSM state enum and opcode helpers for the TD4X core
package td4x_pkg;
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;
  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_HLT    = 4'b1000;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;
  function automatic logic is_add(input logic [3:0] op);
    return op == OP_ADD_A || op == OP_ADD_B;
  endfunction
  function automatic logic is_out(input logic [3:0] op);
    return op == OP_OUT_B || op == OP_OUT_I;
  endfunction
endpackage

// File: rtl/td4x_alu.sv
// td4x_alu: DW-bit adder with carry out, shared by ADD A,IM and ADD B,IM
module td4x_alu #(
  parameter int DW = 4
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_sum,
  output logic          o_co
);
  assign {o_co, o_sum} = {1'b0, i_a} + {1'b0, i_b};
endmodule

// File: rtl/td4x_core.sv
// td4x_core: two-cycle TD4-style CPU (fetch/exec) with optional HALT opcode under TD4X_HALT_EN
module td4x_core
  import td4x_pkg::*;
#(
  parameter int DW = 4,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] inp,
  output logic [DW-1:0] outp,
  output logic          out_valid,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW+3:0] imem_data,
  output logic          halted
);
  state_t        r_state, w_state_nxt;
  logic [DW+3:0] r_ir;
  logic [DW-1:0] r_a, r_b, r_outp;
  logic [AW-1:0] r_pc, w_target;
  logic          r_c, r_out_valid;
  logic [3:0]    w_op;
  logic [DW-1:0] w_im, w_alu_a, w_sum;
  logic          w_co, w_halt_op, w_exec, w_jump;
  assign w_op = r_ir[DW+3:DW];
  assign w_im = r_ir[DW-1:0];
  assign w_alu_a = w_op == OP_ADD_B ? r_b : r_a;
  assign w_jump = w_op == OP_JMP || (w_op == OP_JNC && !r_c);
  assign w_exec = r_state == S_EXEC && !w_halt_op;
  assign outp = r_outp;
  assign out_valid = r_out_valid;
  assign imem_addr = r_pc;
`ifdef TD4X_HALT_EN
  assign w_halt_op = w_op == OP_HLT;
`else
  assign w_halt_op = 1'b0;
`endif
  if (AW <= DW) begin : g_tgt_narrow
    assign w_target = w_im[AW-1:0];
  end else begin : g_tgt_wide
    assign w_target = {{(AW-DW){1'b0}}, w_im};
  end
  td4x_alu #(.DW(DW)) u_alu (
    .i_a   (w_alu_a),
    .i_b   (w_im),
    .o_sum (w_sum),
    .o_co  (w_co)
  );
  // state register: reset always restarts fetching, discarding any pending ack
  always_ff @(posedge clk)
    r_state <= !reset ? S_FETCH : w_state_nxt;
  // next state: wait for ack in FETCH, one cycle in EXEC, HALT is sticky
  always_comb
    w_state_nxt = r_state == S_FETCH ? (imem_ack ? S_EXEC : S_FETCH) :
                  r_state == S_EXEC  ? (w_halt_op ? S_HALT : S_FETCH) : S_HALT;
  // FSM outputs: fetch request only in FETCH, halted flag only when the feature exists
  always_comb begin
    imem_req = r_state == S_FETCH;
`ifdef TD4X_HALT_EN
    halted = r_state == S_HALT;
`else
    halted = 1'b0;
`endif
  end
  // datapath: IR latches on ack, registers/PC/carry update once per EXEC
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ir        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_outp      <= '0;
      r_out_valid <= 1'b0;
      r_pc        <= '0;
      r_c         <= 1'b0;
    end else begin
      r_out_valid <= w_exec && is_out(w_op);
      if (r_state == S_FETCH && imem_ack)
        r_ir <= imem_data;
      if (w_exec) begin
        r_a    <= w_op == OP_ADD_A  ? w_sum :
                  w_op == OP_MOV_AB ? r_b :
                  w_op == OP_IN_A   ? inp :
                  w_op == OP_MOV_AI ? w_im : r_a;
        r_b    <= w_op == OP_ADD_B  ? w_sum :
                  w_op == OP_MOV_BA ? r_a :
                  w_op == OP_IN_B   ? inp :
                  w_op == OP_MOV_BI ? w_im : r_b;
        r_outp <= w_op == OP_OUT_B ? r_b : w_op == OP_OUT_I ? w_im : r_outp;
        r_c    <= is_add(w_op) && w_co;
        r_pc   <= w_jump ? w_target : r_pc + AW'(1);
      end
    end
  end
endmodule

// File: tb/tb_td4x_core.sv
// tb_td4x_core: directed-program bench for td4x_core (DW=4, AW=4); halt test needs TD4X_HALT_EN
module tb_td4x_core;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] inp = 4'h0;
  logic [3:0] outp;
  logic       out_valid, imem_req, imem_ack, halted;
  logic [3:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] mem [16];
  logic       stall = 1'b0;
  int         checks = 0;
  int         errors = 0;

  td4x_core #(.DW(4), .AW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .inp       (inp),
    .outp      (outp),
    .out_valid (out_valid),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];
  assign imem_ack  = imem_req && !(stall && imem_addr == 4'd2);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
  endtask

  task automatic wait_fetch(input string tag, input logic [3:0] a, input int budget);
    int n = 0;
    while (!(imem_req && imem_addr == a) && n < budget) begin
      step();
      n++;
    end
    chk(tag, {imem_req, imem_addr}, {1'b1, a});
  endtask

  task automatic wait_out(input string tag, input logic [3:0] exp);
    int n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_data"}, outp, exp);
    step();
    chk({tag, "_pulse"}, out_valid, 1'b0);
  endtask

  initial begin
    // P1: carry from ADD A,1 blocks JNC 7; ADD B,3 clears carry so JNC 9 is taken
    mem = '{8'h3F, 8'h01, 8'hE7, 8'h40, 8'h53, 8'h90, 8'hE9, 8'hB1,
            8'hB1, 8'hBC, 8'hFA, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1};
    do_reset();
    chk("rst_outp", outp, 4'h0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_req", imem_req, 1'b1);
    chk("rst_addr", imem_addr, 4'h0);
    chk("rst_halted", halted, 1'b0);
    wait_fetch("carry_jnc_not_taken", 4'd3, 10);
    wait_out("carry_a_zero", 4'h3);
    wait_out("jnc_taken", 4'hC);
    wait_fetch("jmp_loop", 4'hA, 10);
    // P2: fetch of address 2 stalls three cycles, then A=0xA is moved out through B
    mem = '{8'h3A, 8'h40, 8'h90, 8'h05, 8'h40, 8'h90, 8'hF6, 8'hB1,
            8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1};
    stall = 1'b1;
    do_reset();
    wait_fetch("stall_reach", 4'd2, 10);
    for (int i = 0; i < 3; i++) begin
      chk("stall_addr", {imem_req, imem_addr}, {1'b1, 4'd2});
      chk("stall_outp", {out_valid, outp}, 5'h00);
      step();
    end
    stall = 1'b0;
    chk("stall_ack_addr", {imem_req, imem_addr}, {1'b1, 4'd2});
    step();
    chk("exec_no_req", imem_req, 1'b0);
    wait_out("out_b_a", 4'hA);
    wait_out("out_b_f", 4'hF);
    // P3: JMP F then ADD A,0 at F wraps to 0 with carry clear, so JNC 5 at 0 is taken
    mem = '{8'hE5, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'h3F, 8'h01, 8'hFF,
            8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'h00};
    do_reset();
    wait_fetch("wrap_reach_f", 4'hF, 20);
    step();
    chk("wrap_exec", imem_req, 1'b0);
    step();
    chk("wrap_addr0", {imem_req, imem_addr}, {1'b1, 4'h0});
    repeat (2) step();
    chk("wrap_carry0", {imem_req, imem_addr}, {1'b1, 4'h5});
    chk("wrap_no_out", out_valid, 1'b0);
    // P4: IN A/B, MOV A,B, ADD overflow, undefined opcode, OUT IM
    mem = '{8'h20, 8'h40, 8'h90, 8'h60, 8'h53, 8'h90, 8'h1F, 8'h07,
            8'h40, 8'h90, 8'hD0, 8'hBE, 8'hFC, 8'hB1, 8'hB1, 8'hB1};
    inp = 4'h9;
    do_reset();
    wait_out("in_a", 4'h9);
    wait_out("in_b_add", 4'hC);
    wait_out("add_wrap", 4'h3);
    wait_out("out_im", 4'hE);
    wait_fetch("nop_loop", 4'hC, 10);
    // reset in the middle of a stalled fetch restarts at address 0
    mem = '{8'h3A, 8'h40, 8'h90, 8'hF3, 8'hB1, 8'hB1, 8'hB1, 8'hB1,
            8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1};
    stall = 1'b1;
    do_reset();
    wait_fetch("mid_reach", 4'd2, 10);
    step();
    stall = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("mid_rst_addr", {imem_req, imem_addr, outp}, {1'b1, 4'h0, 4'h0});
`ifdef TD4X_HALT_EN
    mem = '{8'h35, 8'h80, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1,
            8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1};
    do_reset();
    repeat (4) step();
    for (int i = 0; i < 10; i++) begin
      chk("halt_state", {halted, imem_req}, 2'b10);
      step();
    end
    chk("halt_no_out", out_valid, 1'b0);
    do_reset();
    chk("halt_resume", {halted, imem_req, imem_addr}, {1'b0, 1'b1, 4'h0});
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
